// File: rtl/single_cycle_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core.
// Holds the opcode/funct encodings, the ALU control enum and the fixed program ROM.
package single_cycle_cpu_pkg;

   localparam int IMEM_WORDS = 64;
   localparam int DMEM_WORDS = 64;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ZERO,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_ctl_e;

   // Words beyond the program read as 0x00000000, which decodes as a NOP.
   function automatic logic [31:0] rom_word(input logic [5:0] idx);
      logic [31:0] w;
      case (idx)
         6'd0:    w = 32'h20010005;
         6'd1:    w = 32'h20020003;
         6'd2:    w = 32'h00221820;
         6'd3:    w = 32'h00222022;
         6'd4:    w = 32'hAC030000;
         6'd5:    w = 32'h8C050000;
         6'd6:    w = 32'h10A30001;
         6'd7:    w = 32'h20060001;
         6'd8:    w = 32'h0041302A;
         6'd9:    w = 32'h08000009;
         default: w = 32'h00000000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/single_cycle_cpu_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write port.
// $0 is hardwired to zero; an active-low reset clears every register asynchronously.
module single_cycle_cpu_regfile
   import single_cycle_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd
);

   logic [31:0] r_regs [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we && (i_wa != 5'd0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset core with internal program ROM and data RAM.
// Only the ALU result and the next-PC value are visible at the boundary.
module single_cycle_cpu
   import single_cycle_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] result,
   output logic [31:0] inPc1
);

   logic [31:0] r_pc;
   logic [31:0] r_dmem [DMEM_WORDS];

   logic [31:0] w_instr;
   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_sext;
   logic [31:0] w_rs_data, w_rt_data;
   logic [31:0] w_alu_b, w_alu_out;
   logic [31:0] w_mem_rdata, w_wb_data;
   logic [31:0] w_pc4;
   logic [4:0]  w_wa;
   alu_ctl_e    w_alu_ctl;
   logic        w_use_imm, w_reg_we, w_wr_rd, w_mem_we, w_mem_to_reg, w_is_beq, w_is_j;

   assign w_instr = rom_word(r_pc[7:2]);
   assign w_op    = w_instr[31:26];
   assign w_rs    = w_instr[25:21];
   assign w_rt    = w_instr[20:16];
   assign w_rd    = w_instr[15:11];
   assign w_funct = w_instr[5:0];
   assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};

   always_comb begin
      w_alu_ctl    = ALU_ZERO;
      w_use_imm    = 1'b0;
      w_reg_we     = 1'b0;
      w_wr_rd      = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_to_reg = 1'b0;
      w_is_beq     = 1'b0;
      w_is_j       = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_wr_rd  = 1'b1;
            w_reg_we = 1'b1;
            case (w_funct)
               FN_ADD:  w_alu_ctl = ALU_ADD;
               FN_SUB:  w_alu_ctl = ALU_SUB;
               FN_AND:  w_alu_ctl = ALU_AND;
               FN_OR:   w_alu_ctl = ALU_OR;
               FN_SLT:  w_alu_ctl = ALU_SLT;
               default: w_reg_we  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_alu_ctl = ALU_ADD;
            w_use_imm = 1'b1;
            w_reg_we  = 1'b1;
         end
         OP_LW: begin
            w_alu_ctl    = ALU_ADD;
            w_use_imm    = 1'b1;
            w_reg_we     = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         OP_SW: begin
            w_alu_ctl = ALU_ADD;
            w_use_imm = 1'b1;
            w_mem_we  = 1'b1;
         end
         OP_BEQ: begin
            w_alu_ctl = ALU_SUB;
            w_is_beq  = 1'b1;
         end
         OP_J:    w_is_j = 1'b1;
         default: ;
      endcase
   end

   single_cycle_cpu_regfile u_rf (
      .clk   (clk),
      .rst_n (reset),
      .i_ra1 (w_rs),
      .i_ra2 (w_rt),
      .o_rd1 (w_rs_data),
      .o_rd2 (w_rt_data),
      .i_we  (w_reg_we),
      .i_wa  (w_wa),
      .i_wd  (w_wb_data)
   );

   assign w_alu_b = w_use_imm ? w_sext : w_rt_data;

   always_comb begin
      w_alu_out = '0;
      case (w_alu_ctl)
         ALU_ADD: w_alu_out = w_rs_data + w_alu_b;
         ALU_SUB: w_alu_out = w_rs_data - w_alu_b;
         ALU_AND: w_alu_out = w_rs_data & w_alu_b;
         ALU_OR:  w_alu_out = w_rs_data | w_alu_b;
         ALU_SLT: w_alu_out = {31'd0, $signed(w_rs_data) < $signed(w_alu_b)};
         default: w_alu_out = '0;
      endcase
   end

   // Data RAM is deliberately left out of reset so its contents survive a core reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_dmem[w_alu_out[7:2]] <= w_rt_data;
   end

   assign w_mem_rdata = r_dmem[w_alu_out[7:2]];
   assign w_wb_data   = w_mem_to_reg ? w_mem_rdata : w_alu_out;
   assign w_wa        = w_wr_rd ? w_rd : w_rt;

   assign w_pc4 = r_pc + 32'd4;

   always_comb begin
      inPc1 = w_pc4;
      if (w_is_j)
         inPc1 = {w_pc4[31:28], w_instr[25:0], 2'b00};
      else if (w_is_beq && (w_rs_data == w_rt_data))
         inPc1 = w_pc4 + {w_sext[29:0], 2'b00};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_pc <= '0;
      else        r_pc <= inPc1;
   end

   assign result = w_alu_out;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: walks the built-in program, checks result/next-PC
// each cycle plus register/RAM state, then replays the program after a mid-run reset.
module tb_single_cycle_cpu;

   logic        clk;
   logic        reset;
   logic [31:0] result;
   logic [31:0] inPc1;

   int n_cmp = 0;
   int n_err = 0;

   single_cycle_cpu dut (
      .clk    (clk),
      .reset  (reset),
      .result (result),
      .inPc1  (inPc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected {result, inPc1} for each instruction executed from reset.
   logic [31:0] exp_res [10] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd0, 32'd0, 32'd0,
                                 32'd1, 32'd0, 32'd0};
   logic [31:0] exp_npc [10] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                 32'h20, 32'h24, 32'h24, 32'h24};

   task automatic run_program(input string pass);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("%s_res%0d", pass, i), result, exp_res[i]);
         chk($sformatf("%s_npc%0d", pass, i), inPc1, exp_npc[i]);
         if (i == 4) begin
            chk({pass, "_r1"}, dut.u_rf.r_regs[1], 32'd5);
            chk({pass, "_r2"}, dut.u_rf.r_regs[2], 32'd3);
            chk({pass, "_r3"}, dut.u_rf.r_regs[3], 32'd8);
            chk({pass, "_r4"}, dut.u_rf.r_regs[4], 32'd2);
         end
         if (i == 7) chk({pass, "_r6_pre_slt"}, dut.u_rf.r_regs[6], 32'd0);
         @(negedge clk);
         #1;
      end
      chk({pass, "_r5"}, dut.u_rf.r_regs[5], 32'd8);
      chk({pass, "_r6"}, dut.u_rf.r_regs[6], 32'd1);
      chk({pass, "_ram0"}, dut.r_dmem[0], 32'd8);
      for (int k = 0; k < 3; k++) begin
         chk({pass, "_jloop_npc"}, inPc1, 32'h24);
         chk({pass, "_jloop_res"}, result, 32'd0);
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b0;
      #1;
      chk("rst_res_early", result, 32'd5);
      chk("rst_npc_early", inPc1, 32'h04);
      @(negedge clk);
      #1;
      chk("rst_res_hold", result, 32'd5);
      chk("rst_npc_hold", inPc1, 32'h04);
      chk("rst_pc", dut.r_pc, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      run_program("p1");

      // Drop reset between edges: the core must return to 0x00 without a clock.
      #2;
      reset = 1'b0;
      #1;
      chk("async_pc", dut.r_pc, 32'h0);
      chk("async_npc", inPc1, 32'h04);
      chk("async_res", result, 32'd5);
      chk("async_r3", dut.u_rf.r_regs[3], 32'd0);
      chk("async_r6", dut.u_rf.r_regs[6], 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      run_program("p2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL timeout: got no finish expected finish before 5000ns");
      $fatal(1, "timeout");
   end

endmodule
